enemy_bullet: RTL and testbench
===============================

ENEMY_BULLET -- requirements
Module: enemy_bullet

Interface
REQ-001 SHALL have parameter SPEED_P, default 4, pixels the bullet moves down per frame.
REQ-002 SHALL have parameter FIRE_DELAY_P, default 60, cooldown in frames between bullets.
REQ-003 SHALL have parameter PLAYER_TOP_P, default 430, top row of the player ship.
REQ-004 SHALL have parameter PLAYER_BOT_P, default 450, bottom row of the player ship.
REQ-005 SHALL have parameter SCREEN_BOT_P, default 479, last visible row.
REQ-006 SHALL have port clk_i  input  1  single clock for all state.
REQ-007 SHALL have port reset_ni  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port frame_i  input  1  one-cycle pulse per video frame.
REQ-009 SHALL have port enable_i  input  1  game running; low freezes the block.
REQ-010 SHALL have port resume_i  input  1  centre button; releases the HIT state.
REQ-011 SHALL have port src_valid_i  input  1  alien grid offers a shooter.
REQ-012 SHALL have port src_x_i  input  10  shooter left x.
REQ-013 SHALL have port src_y_i  input  10  shooter bottom y.
REQ-014 SHALL have port src_ready_o  output  1  block accepts a shooter.
REQ-015 SHALL have port pos_left_i  input  10  player left x.
REQ-016 SHALL have port pos_right_i  input  10  player right x.
REQ-017 SHALL have port hit_o  output  1  one-cycle pulse on player hit; drives the player's hit input.
REQ-018 SHALL have port bullet_o  output  1  bullet visible.
REQ-019 SHALL have port bullet_left_o, bullet_right_o, bullet_top_o, bullet_bot_o  output  10 each  bullet box.
REQ-020 SHALL have port state_o  output  2  present state, for debug.

Function
REQ-021 SHALL implement states IDLE=00, ARMED=01, FLYING=10, HIT=11.
REQ-022 IDLE SHALL count frame_i pulses (only while enable_i=1) and enter ARMED on the frame that brings the count to FIRE_DELAY_P-1; the count then clears.
REQ-023 ARMED SHALL drive src_ready_o=1; on src_valid_i & src_ready_o it SHALL latch left=src_x_i and top=src_y_i and enter FLYING on the next clock.
REQ-024 src_ready_o SHALL be 0 in all states except ARMED, and SHALL also be 0 while enable_i=0.
REQ-025 The bullet box SHALL be right=left+6 and bot=top+10, using 10-bit wrap-free arithmetic; bullet_o SHALL be 1 only in FLYING.
REQ-026 On frame_i in FLYING, the collision test SHALL use the current coordinates: bot>=PLAYER_TOP_P & top<=PLAYER_BOT_P & right>pos_left_i & left<pos_right_i.
REQ-027 On a collision, the block SHALL enter HIT and assert hit_o for exactly the first cycle of HIT.
REQ-028 Otherwise, if top+SPEED_P+10 > SCREEN_BOT_P, the block SHALL enter IDLE (miss) with no hit_o.
REQ-029 Otherwise the block SHALL set top=top+SPEED_P and stay in FLYING.
REQ-030 Collision SHALL take priority over the miss condition in the same frame.
REQ-031 HIT SHALL hold until resume_i=1, then enter IDLE with the cooldown cleared; the player hit bookkeeping is not repeated (hit_o is not re-asserted).
REQ-032 While enable_i=0, state, coordinates and counters SHALL hold, frame_i SHALL be ignored, and hit_o SHALL be 0.
REQ-033 resume_i SHALL be ignored in all states except HIT.

Reset
REQ-034 reset_ni=0 SHALL immediately force IDLE, clear the cooldown count and clear the coordinates to 0, independent of clk_i.
REQ-035 During reset, all outputs SHALL be 0 (bullet_right_o=6 and bullet_bot_o=10 follow from the cleared coordinates).
REQ-036 Reset asserted mid-flight or in HIT SHALL discard the bullet; hit_o SHALL not pulse.

Configuration
REQ-037 With macro ENEMY_BULLET_JITTER_EN defined, the block SHALL include an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) stepped on every frame_i; the IDLE cooldown length SHALL be FIRE_DELAY_P+lfsr[4:0], sampled on entry to IDLE.
REQ-038 Without ENEMY_BULLET_JITTER_EN, the block SHALL have no LFSR and the cooldown SHALL be exactly FIRE_DELAY_P frames.

Verification
REQ-039 Reset release, enable_i=1, 60 frames -> state_o=01 and src_ready_o=1 after the 60th frame_i.
REQ-040 In ARMED, src_valid_i with x=300, y=380 -> FLYING with top=380, left=300, right=306; after 10 frames top=420.
REQ-041 Player at left 280, right 320; bullet launched at x=300, y=380 -> hit_o single pulse at top=420, state HIT; resume_i -> IDLE.
REQ-042 Player at left 9, right 49; bullet at x=300 -> no hit_o; IDLE entered once top+14>479 (top=468 at launch y=380).
REQ-043 enable_i=0 for 20 frames mid-flight -> top unchanged; the flight resumes on the next enabled frame.
REQ-044 reset_ni pulsed low mid-flight -> outputs 0 asynchronously, state IDLE, no hit_o.

Source files
------------

// File: rtl/enemy_bullet.sv
// Enemy bullet: cooldown, shooter handshake, downward flight, player collision and HIT hold.
// Optional macro ENEMY_BULLET_JITTER_EN adds LFSR jitter to the IDLE cooldown length.
module enemy_bullet #(
  parameter int SPEED_P      = 4,
  parameter int FIRE_DELAY_P = 60,
  parameter int PLAYER_TOP_P = 430,
  parameter int PLAYER_BOT_P = 450,
  parameter int SCREEN_BOT_P = 479
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       frame_i,
  input  logic       enable_i,
  input  logic       resume_i,
  input  logic       src_valid_i,
  input  logic [9:0] src_x_i,
  input  logic [9:0] src_y_i,
  output logic       src_ready_o,
  input  logic [9:0] pos_left_i,
  input  logic [9:0] pos_right_i,
  output logic       hit_o,
  output logic       bullet_o,
  output logic [9:0] bullet_left_o,
  output logic [9:0] bullet_right_o,
  output logic [9:0] bullet_top_o,
  output logic [9:0] bullet_bot_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    FLYING = 2'b10,
    HIT    = 2'b11
  } state_t;

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [9:0]  top_q;
  logic [9:0]  left_q;
  logic        hit_q;
  logic [15:0] limit;

  // Geometry is evaluated one bit wider so comparisons never wrap.
  logic [10:0] right_w;
  logic [10:0] bot_w;
  logic [10:0] next_bot_w;
  logic        collide;
  logic        miss;
  logic        enter_idle;

  assign right_w    = {1'b0, left_q} + 11'd6;
  assign bot_w      = {1'b0, top_q} + 11'd10;
  assign next_bot_w = {1'b0, top_q} + 11'(SPEED_P) + 11'd10;

  assign collide = (bot_w >= 11'(PLAYER_TOP_P)) &&
                   ({1'b0, top_q} <= 11'(PLAYER_BOT_P)) &&
                   (right_w > {1'b0, pos_left_i}) &&
                   (left_q < pos_right_i);
  assign miss    = next_bot_w > 11'(SCREEN_BOT_P);

  assign enter_idle = enable_i &&
                      (((state_q == FLYING) && frame_i && !collide && miss) ||
                       ((state_q == HIT) && resume_i));

`ifdef ENEMY_BULLET_JITTER_EN
  logic [7:0]  lfsr_q;
  logic [15:0] limit_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      lfsr_q  <= 8'hA5;
      limit_q <= 16'(FIRE_DELAY_P) + 16'd5;
    end else begin
      if (enable_i && frame_i) begin
        lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
      if (enter_idle) begin
        limit_q <= 16'(FIRE_DELAY_P) + {11'd0, lfsr_q[4:0]};
      end
    end
  end

  assign limit = limit_q;
`else
  assign limit = 16'(FIRE_DELAY_P);
`endif

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      top_q   <= '0;
      left_q  <= '0;
      hit_q   <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      if (enable_i) begin
        case (state_q)
          IDLE: begin
            if (frame_i) begin
              if (cnt_q == limit - 16'd1) begin
                state_q <= ARMED;
                cnt_q   <= '0;
              end else begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
          ARMED: begin
            if (src_valid_i) begin
              left_q  <= src_x_i;
              top_q   <= src_y_i;
              state_q <= FLYING;
            end
          end
          FLYING: begin
            if (frame_i) begin
              if (collide) begin
                state_q <= HIT;
                hit_q   <= 1'b1;
              end else if (miss) begin
                state_q <= IDLE;
                cnt_q   <= '0;
              end else begin
                top_q <= top_q + 10'(SPEED_P);
              end
            end
          end
          HIT: begin
            if (resume_i) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign src_ready_o    = (state_q == ARMED) && enable_i;
  assign hit_o          = hit_q && enable_i;
  assign bullet_o       = (state_q == FLYING);
  assign bullet_left_o  = left_q;
  assign bullet_right_o = right_w[9:0];
  assign bullet_top_o   = top_q;
  assign bullet_bot_o   = bot_w[9:0];
  assign state_o        = state_q;

endmodule

// File: tb/tb_enemy_bullet.sv
// Scoreboard bench for enemy_bullet: stimulus queues expected state events, a monitor checks them.
module tb_enemy_bullet;

  logic       clk_i = 1'b0;
  logic       reset_ni, frame_i, enable_i, resume_i, src_valid_i;
  logic [9:0] src_x_i, src_y_i, pos_left_i, pos_right_i;
  logic       src_ready_o, hit_o, bullet_o;
  logic [9:0] bullet_left_o, bullet_right_o, bullet_top_o, bullet_bot_o;
  logic [1:0] state_o;

  enemy_bullet dut (
    .clk_i(clk_i), .reset_ni(reset_ni), .frame_i(frame_i), .enable_i(enable_i),
    .resume_i(resume_i), .src_valid_i(src_valid_i), .src_x_i(src_x_i), .src_y_i(src_y_i),
    .src_ready_o(src_ready_o), .pos_left_i(pos_left_i), .pos_right_i(pos_right_i),
    .hit_o(hit_o), .bullet_o(bullet_o), .bullet_left_o(bullet_left_o),
    .bullet_right_o(bullet_right_o), .bullet_top_o(bullet_top_o),
    .bullet_bot_o(bullet_bot_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0] st;
    logic       hit;
    logic [9:0] top;
    logic [9:0] left;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hit_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: any state change or hit pulse is a DUT event checked against the queue head.
  initial begin
    logic [1:0] prev_st;
    obs_t       e;
    prev_st = 2'b00;
    forever begin
      @(negedge clk_i);
      if (reset_ni) begin
        if (hit_o) hit_seen++;
        if (state_o != prev_st || hit_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got state=%0d hit=%0d top=%0d, expected none",
                     state_o, hit_o, bullet_top_o);
          end else begin
            e = exp_q.pop_front();
            check("evt_state", 32'(state_o), 32'(e.st));
            check("evt_hit", 32'(hit_o), 32'(e.hit));
            check("evt_top", 32'(bullet_top_o), 32'(e.top));
            check("evt_left", 32'(bullet_left_o), 32'(e.left));
          end
        end
      end
      prev_st = state_o;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      tick();
    end
  endtask

  task automatic expect_evt(input logic [1:0] st, input logic hit, input int top, input int left);
    exp_q.push_back({st, hit, 10'(top), 10'(left)});
  endtask

  task automatic launch(input int x, input int y);
    src_valid_i = 1'b1;
    src_x_i     = 10'(x);
    src_y_i     = 10'(y);
    tick();
    src_valid_i = 1'b0;
  endtask

  initial begin
    reset_ni = 1'b0; frame_i = 1'b0; enable_i = 1'b0; resume_i = 1'b0;
    src_valid_i = 1'b0; src_x_i = '0; src_y_i = '0;
    pos_left_i = 10'd9; pos_right_i = 10'd49;
    tick(); tick();

    check("rst_state", 32'(state_o), 0);
    check("rst_ready", 32'(src_ready_o), 0);
    check("rst_bullet", 32'(bullet_o), 0);
    check("rst_hit", 32'(hit_o), 0);
    check("rst_right", 32'(bullet_right_o), 6);
    check("rst_bot", 32'(bullet_bot_o), 10);

    // Cooldown: 59 frames stays IDLE, the 60th arms.
    reset_ni = 1'b1;
    enable_i = 1'b1;
    resume_i = 1'b1;
    frames(59);
    resume_i = 1'b0;
    check("cool59_state", 32'(state_o), 0);
    check("cool59_ready", 32'(src_ready_o), 0);
    expect_evt(2'b01, 1'b0, 0, 0);
    frames(1);
    check("armed_ready", 32'(src_ready_o), 1);
    enable_i = 1'b0;
    #1;
    check("armed_ready_disabled", 32'(src_ready_o), 0);
    enable_i = 1'b1;

    // Launch and fly with the player far away.
    expect_evt(2'b10, 1'b0, 380, 300);
    launch(300, 380);
    check("fly_right", 32'(bullet_right_o), 306);
    check("fly_bot", 32'(bullet_bot_o), 390);
    check("fly_bullet", 32'(bullet_o), 1);
    check("fly_ready", 32'(src_ready_o), 0);
    frames(10);
    check("fly_top10", 32'(bullet_top_o), 420);

    // Freeze for 20 frames, then one enabled frame moves it on.
    enable_i = 1'b0;
    frames(20);
    check("frozen_top", 32'(bullet_top_o), 420);
    check("frozen_state", 32'(state_o), 2);
    enable_i = 1'b1;
    frames(1);
    check("resume_top", 32'(bullet_top_o), 424);

    // Miss: last FLYING top is 468, next frame leaves the screen.
    frames(11);
    check("miss_last_top", 32'(bullet_top_o), 468);
    check("miss_last_state", 32'(state_o), 2);
    expect_evt(2'b00, 1'b0, 468, 300);
    frames(1);

    // Hit path.
    expect_evt(2'b01, 1'b0, 468, 300);
    frames(60);
    pos_left_i = 10'd280; pos_right_i = 10'd320;
    expect_evt(2'b10, 1'b0, 380, 300);
    launch(300, 380);
    frames(10);
    check("prehit_state", 32'(state_o), 2);
    expect_evt(2'b11, 1'b1, 420, 300);
    frames(1);
    tick(); tick();
    check("hit_hold_state", 32'(state_o), 3);
    check("hit_hold_pulse", 32'(hit_o), 0);
    expect_evt(2'b00, 1'b0, 420, 300);
    resume_i = 1'b1;
    tick();
    resume_i = 1'b0;
    tick();
    check("resume_ready", 32'(src_ready_o), 0);

    // Reset mid-flight.
    expect_evt(2'b01, 1'b0, 420, 300);
    frames(60);
    expect_evt(2'b10, 1'b0, 380, 300);
    launch(300, 380);
    frames(3);
    check("pre_rst_top", 32'(bullet_top_o), 392);
    reset_ni = 1'b0;
    #1;
    check("arst_state", 32'(state_o), 0);
    check("arst_bullet", 32'(bullet_o), 0);
    check("arst_top", 32'(bullet_top_o), 0);
    check("arst_left", 32'(bullet_left_o), 0);
    check("arst_right", 32'(bullet_right_o), 6);
    check("arst_bot", 32'(bullet_bot_o), 10);
    check("arst_hit", 32'(hit_o), 0);
    tick(); tick();
    reset_ni = 1'b1;
    frames(3);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("queue_drained", 32'(exp_q.size()), 0);
    check("hit_pulse_count", 32'(hit_seen), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
